// File: rtl/siganfu_weapon_ctrl.sv
// SIGANFU turret fire control: gates single/burst/auto fire on lock, IFF and command,
// and sequences the magazine, reload, overheat cooldown and ammo-exhausted shutdown.
module siganfu_weapon_ctrl #(
  parameter int MAG_SIZE   = 25,
  parameter int MAG_COUNT  = 3,
  parameter int FIRE_CYC   = 5,
  parameter int GAP_CYC    = 5,
  parameter int BURST_LEN  = 3,
  parameter int RELOAD_CYC = 50,
  parameter int COOL_CYC   = 100,
  localparam int RW = $clog2(MAG_SIZE + 1),
  localparam int MW = (MAG_COUNT == 0) ? 1 : $clog2(MAG_COUNT + 1)
) (
  input  logic          sysclk,
  input  logic          reboot,
  input  logic          target_locked,
  input  logic          is_enemy,
  input  logic          fire_command,
  input  logic [1:0]    firing_mode,
  input  logic          overheat_sensor,
  output logic [2:0]    current_state,
  output logic          criticality_alert,
  output logic          fire_trigger,
  output logic [RW-1:0] rounds_left,
  output logic [MW-1:0] mags_left
);

  localparam int SHOT_CYC = FIRE_CYC + GAP_CYC;
  localparam int TMAX_A   = (SHOT_CYC > RELOAD_CYC) ? SHOT_CYC : RELOAD_CYC;
  localparam int TMAX     = (TMAX_A > COOL_CYC) ? TMAX_A : COOL_CYC;
  localparam int TW       = $clog2(TMAX);
  localparam int SW       = $clog2(BURST_LEN + 1);

  localparam logic [TW-1:0] SHOT_LAST   = TW'(SHOT_CYC - 1);
  localparam logic [TW-1:0] FIRE_LAST   = TW'(FIRE_CYC - 1);
  localparam logic [TW-1:0] RELOAD_LAST = TW'(RELOAD_CYC - 1);
  localparam logic [TW-1:0] COOL_LAST   = TW'(COOL_CYC - 1);
  localparam logic [RW-1:0] FULL_MAG    = RW'(MAG_SIZE);
  localparam logic [MW-1:0] MAG_INIT    = MW'(MAG_COUNT);
  localparam logic [SW-1:0] BURST_N     = SW'(BURST_LEN);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_SINGLE = 3'b001,
    S_AUTO   = 3'b010,
    S_RELOAD = 3'b011,
    S_COOL   = 3'b100,
    S_DOWN   = 3'b101,
    S_BURST  = 3'b110
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] rounds_q, rounds_d;
  logic [MW-1:0] mags_q, mags_d;
  logic [SW-1:0] shots_q, shots_d;
  logic          trig_q, trig_d;
  logic          crit_q, crit_d;
  logic          lock_q, lock_d;
  logic          armed, single_mode, start_shot, go_empty;

  assign armed       = target_locked & is_enemy & fire_command;
  assign single_mode = !(firing_mode == 2'b01 || firing_mode == 2'b10);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    trig_d     = 1'b0;
    rounds_d   = rounds_q;
    mags_d     = mags_q;
    shots_d    = shots_q;
    crit_d     = crit_q;
    lock_d     = lock_q;
    start_shot = 1'b0;
    go_empty   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (armed) begin
          if (overheat_sensor) begin
            state_d = S_COOL;
            timer_d = '0;
          end else if (rounds_q == '0) begin
            go_empty = 1'b1;
          end else if (!(single_mode && lock_q)) begin
            start_shot = 1'b1;
            shots_d    = SW'(1);
            if (firing_mode == 2'b01)      state_d = S_BURST;
            else if (firing_mode == 2'b10) state_d = S_AUTO;
            else                           state_d = S_SINGLE;
          end
        end
      end
      S_SINGLE, S_BURST, S_AUTO: begin
        if (overheat_sensor) begin
          state_d = S_COOL;
          timer_d = '0;
        end else if (timer_q != SHOT_LAST) begin
          timer_d = timer_q + 1'b1;
          trig_d  = (timer_q < FIRE_LAST);
        end else begin
          // End of the gap: decide between the next shot, an empty magazine, or IDLE.
          state_d = S_IDLE;
          timer_d = '0;
          if (state_q == S_SINGLE) lock_d = 1'b1;
          if (armed && rounds_q == '0) begin
            go_empty = 1'b1;
          end else if (armed && (state_q == S_AUTO ||
                                 (state_q == S_BURST && shots_q < BURST_N))) begin
            state_d    = state_q;
            start_shot = 1'b1;
            shots_d    = shots_q + 1'b1;
          end
        end
      end
      S_RELOAD: begin
        if (timer_q == RELOAD_LAST) begin
          state_d  = S_IDLE;
          timer_d  = '0;
          rounds_d = FULL_MAG;
          mags_d   = mags_q - 1'b1;
          if (mags_q == MW'(1)) crit_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_COOL: begin
        if (timer_q == COOL_LAST) begin
          timer_d = '0;
          if (!overheat_sensor) state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DOWN:  state_d = S_DOWN;
      default: state_d = S_IDLE;
    endcase
    if (go_empty) begin
      timer_d = '0;
      state_d = (mags_q != '0) ? S_RELOAD : S_DOWN;
    end
    if (start_shot) begin
      timer_d  = '0;
      trig_d   = 1'b1;
      rounds_d = rounds_q - 1'b1;
    end
    if (!fire_command) lock_d = 1'b0;
  end

  always_ff @(posedge sysclk or posedge reboot) begin
    if (reboot) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      trig_q   <= 1'b0;
      rounds_q <= FULL_MAG;
      mags_q   <= MAG_INIT;
      shots_q  <= '0;
      crit_q   <= (MAG_COUNT == 0);
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      trig_q   <= trig_d;
      rounds_q <= rounds_d;
      mags_q   <= mags_d;
      shots_q  <= shots_d;
      crit_q   <= crit_d;
      lock_q   <= lock_d;
    end
  end

  assign current_state     = state_q;
  assign criticality_alert = crit_q;
  assign fire_trigger      = trig_q;
  assign rounds_left       = rounds_q;
  assign mags_left         = mags_q;

`ifndef SYNTHESIS
  a_no_round_underflow: assert property (@(posedge sysclk) disable iff (reboot)
    start_shot |-> rounds_q != '0);
  a_no_mag_underflow: assert property (@(posedge sysclk) disable iff (reboot)
    (state_q == S_RELOAD && timer_q == RELOAD_LAST) |-> mags_q != '0);
`endif

endmodule

// File: tb/tb_siganfu_weapon_ctrl.sv
// Bench for siganfu_weapon_ctrl: randomized engagements against an event-level reference
// model; a monitor compares every state/trigger change with the expected event queue.
`timescale 1ns/1ps
module tb_siganfu_weapon_ctrl;

  localparam int MAG_SIZE   = 25;
  localparam int MAG_COUNT  = 3;
  localparam int FIRE_CYC   = 5;
  localparam int GAP_CYC    = 5;
  localparam int BURST_LEN  = 3;
  localparam int RELOAD_CYC = 50;
  localparam int COOL_CYC   = 100;
  localparam int RW = $clog2(MAG_SIZE + 1);
  localparam int MW = (MAG_COUNT == 0) ? 1 : $clog2(MAG_COUNT + 1);
  localparam int EW = 24 + 3 + 1 + RW + MW + 1;

  localparam logic [2:0] ST_IDLE   = 3'b000;
  localparam logic [2:0] ST_SINGLE = 3'b001;
  localparam logic [2:0] ST_AUTO   = 3'b010;
  localparam logic [2:0] ST_RELOAD = 3'b011;
  localparam logic [2:0] ST_COOL   = 3'b100;
  localparam logic [2:0] ST_DOWN   = 3'b101;
  localparam logic [2:0] ST_BURST  = 3'b110;

  logic          sysclk = 1'b0;
  logic          reboot = 1'b1;
  logic          target_locked = 1'b0;
  logic          is_enemy = 1'b0;
  logic          fire_command = 1'b0;
  logic [1:0]    firing_mode = 2'b00;
  logic          overheat_sensor = 1'b0;
  logic [2:0]    current_state;
  logic          criticality_alert;
  logic          fire_trigger;
  logic [RW-1:0] rounds_left;
  logic [MW-1:0] mags_left;

  siganfu_weapon_ctrl #(
    .MAG_SIZE(MAG_SIZE), .MAG_COUNT(MAG_COUNT), .FIRE_CYC(FIRE_CYC), .GAP_CYC(GAP_CYC),
    .BURST_LEN(BURST_LEN), .RELOAD_CYC(RELOAD_CYC), .COOL_CYC(COOL_CYC)
  ) dut (
    .sysclk(sysclk), .reboot(reboot), .target_locked(target_locked), .is_enemy(is_enemy),
    .fire_command(fire_command), .firing_mode(firing_mode), .overheat_sensor(overheat_sensor),
    .current_state(current_state), .criticality_alert(criticality_alert),
    .fire_trigger(fire_trigger), .rounds_left(rounds_left), .mags_left(mags_left)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 sysclk = ~sysclk;
  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;
  logic [2:0] prev_state;
  logic       prev_trig;
  logic [EW-1:0] got_ev, exp_ev;

  // Reference model: ammo bookkeeping plus the cycle of the last predicted event.
  int m_rounds, m_mags, m_last;
  bit m_crit, m_down;

  function automatic logic [EW-1:0] pack_ev(input int c, input logic [2:0] st, input logic trg,
                                            input int r, input int m, input logic cr);
    return {c[23:0], st, trg, r[RW-1:0], m[MW-1:0], cr};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_rounds = MAG_SIZE;
    m_mags   = MAG_COUNT;
    m_crit   = (MAG_COUNT == 0);
    m_down   = 1'b0;
    m_last   = cyc;
  endtask

  task automatic push(input int c, input logic [2:0] st, input logic trg);
    exp_q.push_back(pack_ev(c, st, trg, m_rounds, m_mags, m_crit));
    m_last = c;
  endtask

  // Empty magazine seen while armed at edge t: reload (or shut down if none left).
  task automatic model_empty(inout int t);
    if (m_mags > 0) begin
      push(t, ST_RELOAD, 1'b0);
      t += RELOAD_CYC;
      m_rounds = MAG_SIZE;
      m_mags--;
      if (m_mags == 0) m_crit = 1'b1;
      push(t, ST_IDLE, 1'b0);
      t += 1;
    end else begin
      push(t, ST_DOWN, 1'b0);
      m_down = 1'b1;
    end
  endtask

  // Armed on edges base+1 .. base+h, unarmed afterwards, no overheat.
  task automatic model_engage(input int mode, input int base, input int h);
    int t, last_arm, n;
    bit single, lock, more;
    logic [2:0] fst;
    t        = base + 1;
    last_arm = base + h;
    single   = !(mode == 1 || mode == 2);
    lock     = 1'b0;
    fst      = (mode == 1) ? ST_BURST : (mode == 2) ? ST_AUTO : ST_SINGLE;
    while (!m_down && t <= last_arm) begin
      if (m_rounds == 0) begin
        model_empty(t);
      end else if (single && lock) begin
        break;
      end else begin
        n = 0;
        more = 1'b1;
        while (more) begin
          m_rounds--;
          n++;
          push(t, fst, 1'b1);
          push(t + FIRE_CYC, fst, 1'b0);
          t += FIRE_CYC + GAP_CYC;
          if (single) lock = (t <= last_arm);
          if (t <= last_arm && m_rounds == 0) begin
            model_empty(t);
            more = 1'b0;
          end else if (t <= last_arm && (fst == ST_AUTO || (fst == ST_BURST && n < BURST_LEN))) begin
            more = 1'b1;
          end else begin
            push(t, ST_IDLE, 1'b0);
            t += 1;
            more = 1'b0;
          end
        end
      end
    end
  endtask

  // Overheat either together with arming (pre) or on the 2nd cycle of the first shot.
  task automatic model_overheat(input int mode, input bit pre, input int base, input int l);
    int e0, oh_last, k;
    logic [2:0] fst;
    if (m_down) return;
    fst = (mode == 1) ? ST_BURST : (mode == 2) ? ST_AUTO : ST_SINGLE;
    if (pre) begin
      e0 = base + 1;
      oh_last = base + l;
    end else begin
      m_rounds--;
      push(base + 1, fst, 1'b1);
      e0 = base + 3;
      oh_last = base + 2 + l;
    end
    push(e0, ST_COOL, 1'b0);
    k = 1;
    while (e0 + COOL_CYC * k <= oh_last) k++;
    push(e0 + COOL_CYC * k, ST_IDLE, 1'b0);
  endtask

  // ---------------- monitor ----------------
  task automatic mon_reset();
    prev_state = ST_IDLE;
    prev_trig  = 1'b0;
  endtask

  always @(negedge sysclk) begin
    if (mon_en) begin
      if (current_state !== prev_state || fire_trigger !== prev_trig) begin
        checks++;
        got_ev = pack_ev(cyc, current_state, fire_trigger, rounds_left, mags_left, criticality_alert);
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: cyc=%0d state=%b trig=%b rounds=%0d mags=%0d crit=%b, none expected",
                   cyc, current_state, fire_trigger, rounds_left, mags_left, criticality_alert);
        end else begin
          exp_ev = exp_q.pop_front();
          if (got_ev !== exp_ev) begin
            errors++;
            $display("FAIL sb_event: got cyc=%0d {st,trg,rnd,mag,crit}=%h expected cyc=%0d %h",
                     cyc, got_ev[EW-25:0], exp_ev[EW-1 -: 24], exp_ev[EW-25:0]);
          end
        end
      end
      prev_state = current_state;
      prev_trig  = fire_trigger;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_until(input int c);
    while (cyc < c) @(negedge sysclk);
  endtask

  task automatic arm(input int mode);
    firing_mode   = mode[1:0];
    target_locked = 1'b1;
    is_enemy      = 1'b1;
    fire_command  = 1'b1;
  endtask

  task automatic engage(input int mode, input int h);
    int base, done;
    base = cyc;
    arm(mode);
    model_engage(mode, base, h);
    wait_until(base + h);
    fire_command  = 1'b0;
    target_locked = 1'($urandom_range(0, 1));
    is_enemy      = 1'($urandom_range(0, 1));
    done = (m_last > base + h) ? m_last : base + h;
    wait_until(done + 2 + $urandom_range(0, 4));
  endtask

  task automatic oh_test(input int mode, input bit pre_in, input int l);
    int base;
    bit pre;
    base = cyc;
    pre  = pre_in || m_rounds == 0;
    arm(mode);
    model_overheat(mode, pre, base, l);
    if (pre) begin
      overheat_sensor = 1'b1;
      wait_until(base + 1);
      fire_command = 1'b0;
      wait_until(base + l);
    end else begin
      wait_until(base + 2);
      overheat_sensor = 1'b1;
      fire_command = 1'b0;
      wait_until(base + 2 + l);
    end
    overheat_sensor = 1'b0;
    wait_until(((m_last > cyc) ? m_last : cyc) + 3);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"}, current_state, ST_IDLE);
    check({tag, "_trig"}, fire_trigger, 0);
    check({tag, "_crit"}, criticality_alert, (MAG_COUNT == 0) ? 1 : 0);
    check({tag, "_rounds"}, rounds_left, MAG_SIZE);
    check({tag, "_mags"}, mags_left, MAG_COUNT);
  endtask

  // Reboot off the clock edge and sample outputs before any further edge arrives.
  task automatic reboot_now(input string tag);
    mon_en = 1'b0;
    fire_command = 1'b0;
    #2 reboot = 1'b1;
    #1 check_reset(tag);
    @(negedge sysclk);
    reboot = 1'b0;
    exp_q.delete();
    model_reset();
    mon_reset();
    mon_en = 1'b1;
    @(negedge sysclk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    repeat (3) @(negedge sysclk);
    check_reset("reset");
    reboot = 1'b0;
    model_reset();
    mon_reset();
    mon_en = 1'b1;
    @(negedge sysclk);

    engage(0, 40);
    engage(0, 40);
    engage(3, 25);
    engage(1, 60);
    engage(2, 300);
    check("auto_mags_after_reload", mags_left, MAG_COUNT - 1);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 4) == 4)
        oh_test($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(20, 260));
      else
        engage($urandom_range(0, 3), $urandom_range(1, 90));
    end

    engage(2, 1500);
    check("down_state", current_state, ST_DOWN);
    check("down_crit", criticality_alert, 1);
    check("down_rounds", rounds_left, 0);
    arm(2);
    repeat (30) @(negedge sysclk);
    check("down_trig_held", fire_trigger, 0);
    check("down_state_held", current_state, ST_DOWN);
    reboot_now("rst_down");

    base = cyc;
    arm(2);
    model_engage(2, base, 40);
    wait_until(base + 3);
    check("pulse_before_rst", fire_trigger, 1);
    reboot_now("rst_pulse");

    base = cyc;
    arm(2);
    model_engage(2, base, 280);
    wait_until(base + 270);
    check("reload_before_rst", current_state, ST_RELOAD);
    check("reload_rounds", rounds_left, 0);
    reboot_now("rst_reload");

    engage(0, 20);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
